// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg: shared widths, frame marker and loader state encoding
package instr_loader_pkg;
  localparam int INSTR_WIDTH = 18;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  typedef enum logic [3:0] {IDLE, LEN_HI, LEN_LO, B0, B1, B2, WRITE, CSUM, DONE, ERROR} state_t;
endpackage

// File: rtl/instr_loader.sv
// instr_loader: framed byte stream to sequential instruction memory writes, holding the CPU in reset
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   imem_we,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  output logic [INSTR_WIDTH-1:0] imem_wdata,
  output logic                   cpu_hold,
  output logic                   load_done,
  output logic                   load_error,
  output logic [ADDR_WIDTH:0]    words_loaded
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  state_t state, nxt;
  logic [ADDR_WIDTH:0] idx, n, idx_inc;
  logic [7:0] len_hi, csum;
  logic [15:0] len;
  logic xfer;
  assign xfer = in_valid && in_ready;
  assign len = {len_hi, in_data};
  assign idx_inc = idx + (ADDR_WIDTH+1)'(1);
  assign words_loaded = idx;
  always_comb begin
    nxt = state;
    case (state)
      IDLE, ERROR: if (xfer && in_data == SYNC_BYTE) nxt = LEN_HI;
      LEN_HI:      if (xfer) nxt = LEN_LO;
      LEN_LO:      if (xfer) nxt = (len == 16'd0 || len > 16'(DEPTH)) ? ERROR : B0;
      B0:          if (xfer) nxt = |in_data[7:2] ? ERROR : B1;
      B1:          if (xfer) nxt = B2;
      B2:          if (xfer) nxt = WRITE;
      WRITE:       nxt = idx_inc == n ? CSUM : B0;
      CSUM:        if (xfer) nxt = in_data == csum ? DONE : ERROR;
      default:     nxt = IDLE;
    endcase
  end
  // handshake and status outputs are registered from the next state so they track state exactly
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      cpu_hold   <= 1'b0;
      imem_we    <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      idx        <= '0;
      n          <= '0;
      len_hi     <= '0;
      csum       <= '0;
    end else begin
      state      <= nxt;
      in_ready   <= !(nxt inside {WRITE, DONE});
      cpu_hold   <= nxt != IDLE;
      imem_we    <= nxt == WRITE;
      load_done  <= nxt == DONE;
      load_error <= nxt == ERROR;
      if (nxt == WRITE) imem_addr <= idx[ADDR_WIDTH-1:0];
      if (state == WRITE) idx <= idx_inc;
      if (xfer) begin
        if (state inside {IDLE, ERROR} && in_data == SYNC_BYTE) begin
          idx  <= '0;
          csum <= '0;
        end
        if (state inside {LEN_HI, LEN_LO, B0, B1, B2}) csum <= csum ^ in_data;
        if (state == LEN_HI) len_hi <= in_data;
        if (state == LEN_LO) n <= len[ADDR_WIDTH:0];
        if (state == B0) imem_wdata[17:16] <= in_data[1:0];
        if (state == B1) imem_wdata[15:8] <= in_data;
        if (state == B2) imem_wdata[7:0] <= in_data;
      end
    end
  end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: frame-level reference checks of instr_loader with random gaps and corruptions
module tb_instr_loader;
  logic clk = 0, reset = 0, in_valid = 0;
  logic [7:0] in_data = 0;
  logic in_ready, imem_we, cpu_hold, load_done, load_error;
  logic [9:0] imem_addr;
  logic [17:0] imem_wdata;
  logic [10:0] words_loaded;
  int n_cmp = 0, n_bad = 0, done_cnt = 0;
  logic [27:0] wr_q[$];
  logic [17:0] mem[1024];

  instr_loader dut (.clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_error(load_error), .words_loaded(words_loaded));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // the bench plays the instruction memory and watches the strobes
  always @(negedge clk) begin
    if (imem_we) begin
      wr_q.push_back({imem_addr, imem_wdata});
      mem[imem_addr] = imem_wdata;
      check("we_while_ready", 32'(in_ready), 0);
    end
    if (load_done) begin
      done_cnt++;
      check("done_hold", 32'(cpu_hold), 1);
      check("done_ready", 32'(in_ready), 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int t = 0;
    in_valid = 0;
    repeat (gap) tick();
    in_data = b;
    in_valid = 1;
    while (!in_ready && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) check("ready_timeout", t, 0);
    tick();
    in_valid = 0;
  endtask

  task automatic do_reset();
    reset = 0;
    repeat (2) tick();
    reset = 1;
    tick();
  endtask

  task automatic build(input logic [17:0] w[$], input logic [15:0] len, output logic [7:0] f[$]);
    logic [7:0] x = 0;
    f = {};
    f.push_back(8'hA5);
    f.push_back(len[15:8]);
    f.push_back(len[7:0]);
    foreach (w[i]) begin
      f.push_back({6'b0, w[i][17:16]});
      f.push_back(w[i][15:8]);
      f.push_back(w[i][7:0]);
    end
    for (int i = 1; i < f.size(); i++) x ^= f[i];
    f.push_back(x);
  endtask

  task automatic expect_frame(input string tag, input logic [17:0] ew[$], input int exp_done, input bit exp_err);
    repeat (3) tick();
    check({tag, "_nwr"}, wr_q.size(), ew.size());
    foreach (ew[i]) if (i < wr_q.size()) begin
      check({tag, "_addr"}, 32'(wr_q[i][27:18]), i);
      check({tag, "_data"}, 32'(wr_q[i][17:0]), 32'(ew[i]));
    end
    check({tag, "_done"}, done_cnt, exp_done);
    check({tag, "_err"}, 32'(load_error), 32'(exp_err));
    check({tag, "_hold"}, 32'(cpu_hold), 32'(exp_err));
    check({tag, "_words"}, 32'(words_loaded), ew.size());
  endtask

  task automatic run_frame(input string tag, input logic [7:0] f[$], input int gap, input logic [17:0] ew[$], input int exp_done, input bit exp_err);
    wr_q.delete();
    done_cnt = 0;
    foreach (f[i]) send(f[i], $urandom_range(gap, 0));
    expect_frame(tag, ew, exp_done, exp_err);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] f1[$], f[$];
    logic [17:0] w1[$], w[$], ew[$];
    realtime t0;
    f1 = {8'hA5, 8'h00, 8'h03, 8'h00, 8'h80, 8'h04, 8'h02, 8'h40, 8'h00, 8'h02, 8'h04, 8'h00, 8'hC3};
    w1 = {18'h08004, 18'h24000, 18'h20400};
    repeat (2) tick();
    check("rst_ready", 32'(in_ready), 0);
    check("rst_hold", 32'(cpu_hold), 0);
    check("rst_err", 32'(load_error), 0);
    check("rst_we", 32'(imem_we), 0);
    check("rst_words", 32'(words_loaded), 0);
    reset = 1;
    tick();
    check("rst_ready_after", 32'(in_ready), 1);

    // normal load with in_valid held high
    wr_q.delete();
    done_cnt = 0;
    t0 = $realtime;
    send(f1[0], 0);
    check("t1_hold_after_sync", 32'(cpu_hold), 1);
    for (int i = 1; i < f1.size(); i++) send(f1[i], 0);
    check("t1_cycles", 32'(int'(($realtime - t0) / 10)), 16);
    expect_frame("t1", w1, 1, 0);

    // bad checksum, then SYNC clears the error
    f = f1;
    f[12] = 8'hC2;
    run_frame("t2", f, 0, w1, 0, 1);
    send(8'hA5, 0);
    check("t2_err_cleared", 32'(load_error), 0);
    check("t2_hold_relaunch", 32'(cpu_hold), 1);
    do_reset();

    // length boundaries
    ew = {};
    run_frame("t3_len0", {8'hA5, 8'h00, 8'h00}, 0, ew, 0, 1);
    run_frame("t3_len1025", {8'hA5, 8'h04, 8'h01}, 0, ew, 0, 1);
    w = {};
    for (int i = 0; i < 1024; i++) w.push_back(18'($urandom));
    build(w, 16'd1024, f);
    run_frame("t3_len1024", f, 0, w, 1, 0);
    check("t3_last_addr", 32'(wr_q.size() == 1024 ? wr_q[1023][27:18] : 10'd0), 1023);

    // garbage and random stalls around the reference frame
    f = {8'h11, 8'h22};
    foreach (f1[i]) f.push_back(f1[i]);
    run_frame("t4", f, 3, w1, 1, 0);

    // bad word header
    run_frame("t5", {8'hA5, 8'h00, 8'h01, 8'h04}, 0, ew, 0, 1);

    // randomized frames: good, bad checksum, bad header at a random word
    for (int k = 0; k < 14; k++) begin
      int mode, n, bad;
      mode = $urandom_range(2, 0);
      n = $urandom_range(12, 1);
      w = {};
      for (int i = 0; i < n; i++) w.push_back(18'($urandom));
      if ($urandom_range(1, 0) == 1) w[0][15:8] = 8'hA5;
      build(w, 16'(n), f);
      ew = w;
      if (mode == 1) f[f.size()-1] ^= 8'h01;
      if (mode == 2) begin
        bad = $urandom_range(n - 1, 0);
        f[3 + 3*bad] = {6'($urandom_range(63, 1)), 2'($urandom)};
        while (f.size() > 4 + 3*bad) f.pop_back();
        ew = {};
        for (int i = 0; i < bad; i++) ew.push_back(w[i]);
      end
      for (int g = $urandom_range(2, 0); g > 0; g--) begin
        logic [7:0] b = 8'($urandom);
        f.push_front(b == 8'hA5 ? 8'h5A : b);
      end
      run_frame("rnd", f, 2, ew, mode == 0 ? 1 : 0, mode != 0);
    end

    // reset in the middle of a load
    w = {18'h1ABCD, 18'h0F0F0, 18'h33333, 18'h00001};
    build(w, 16'd4, f);
    wr_q.delete();
    for (int i = 0; i < 9; i++) send(f[i], 0);
    repeat (2) tick();
    check("t6_partial_writes", wr_q.size(), 2);
    reset = 0;
    tick();
    check("t6_rst_hold", 32'(cpu_hold), 0);
    check("t6_rst_ready", 32'(in_ready), 0);
    check("t6_rst_we", 32'(imem_we), 0);
    check("t6_rst_words", 32'(words_loaded), 0);
    check("t6_rst_err", 32'(load_error), 0);
    reset = 1;
    tick();
    check("t6_ready_after", 32'(in_ready), 1);
    check("t6_mem0_kept", 32'(mem[0]), 32'(18'h1ABCD));
    check("t6_mem1_kept", 32'(mem[1]), 32'(18'h0F0F0));
    w = {18'h2AAAA};
    build(w, 16'd1, f);
    run_frame("t6_fresh", f, 1, w, 1, 0);
    check("t6_mem1_after", 32'(mem[1]), 32'(18'h0F0F0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
